// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode, ALU control and FSM definitions for the ALU issue controller.
package alu_pkg;
    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = $clog2(NUM_REGS);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_SLL  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;

    localparam logic [2:0] ALUC_ADD = 3'b000;
    localparam logic [2:0] ALUC_SUB = 3'b001;
    localparam logic [2:0] ALUC_SLL = 3'b010;
    localparam logic [2:0] ALUC_AND = 3'b011;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

    function automatic logic is_legal(input logic [3:0] op);
        return op <= OP_ADDI;
    endfunction

    function automatic logic [DATA_W-1:0] sext6(input logic [5:0] imm);
        return {{(DATA_W-6){imm[5]}}, imm};
    endfunction

    function automatic logic [2:0] op_to_aluc(input logic [3:0] op);
        return op == OP_SUB ? ALUC_SUB :
               op == OP_SLL ? ALUC_SLL :
               op == OP_AND ? ALUC_AND : ALUC_ADD;
    endfunction
endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: register file with R0 hardwired to zero, one write port and three combinational read ports.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int NR = NUM_REGS,
    parameter int AW = $clog2(NR)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr0,
    input  logic [AW-1:0] i_raddr1,
    input  logic [AW-1:0] i_raddr2,
    output logic [DW-1:0] o_rdata0,
    output logic [DW-1:0] o_rdata1,
    output logic [DW-1:0] o_rdata2
);
    logic [DW-1:0] r_mem [NR];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NR; i++) r_mem[i] <= '0;
        end else if (i_we && i_waddr != '0) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata0 = i_raddr0 == '0 ? '0 : r_mem[i_raddr0];
    assign o_rdata1 = i_raddr1 == '0 ? '0 : r_mem[i_raddr1];
    assign o_rdata2 = i_raddr2 == '0 ? '0 : r_mem[i_raddr2];
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: four-state issue/writeback controller that feeds an external 16-bit ALU
// and retires results into an internal register file.
module alu_issue_ctrl
    import alu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [15:0]          instr,
    output logic [DATA_W-1:0]    alu_a,
    output logic [DATA_W-1:0]    alu_b,
    output logic [2:0]           alu_control,
    input  logic [DATA_W-1:0]    alu_result,
    input  logic                 alu_zero,
    output logic                 done,
    output logic                 illegal,
    output logic                 zero_flag,
    input  logic [ADDR_W-1:0]    dbg_addr,
    output logic [DATA_W-1:0]    dbg_data
);
    state_t              r_state;
    logic [15:0]         r_instr;
    logic [DATA_W-1:0]   r_result;
    logic [DATA_W-1:0]   r_alu_a;
    logic [DATA_W-1:0]   r_alu_b;
    logic [2:0]          r_alu_ctrl;
    logic                r_zero;
    logic                r_bad;
    logic                r_done;
    logic                r_illegal;
    logic                r_zero_flag;

    logic [3:0]          w_op;
    logic [ADDR_W-1:0]   w_rd;
    logic [ADDR_W-1:0]   w_rs;
    logic [ADDR_W-1:0]   w_rt;
    logic [DATA_W-1:0]   w_rdata_s;
    logic [DATA_W-1:0]   w_rdata_t;
    logic                w_we;

    assign w_op = r_instr[15:12];
    assign w_rd = r_instr[11:9];
    assign w_rs = r_instr[8:6];
    assign w_rt = r_instr[5:3];
    assign w_we = r_state == S_WB && !r_bad;

    alu_regfile u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_we     (w_we),
        .i_waddr  (w_rd),
        .i_wdata  (r_result),
        .i_raddr0 (w_rs),
        .i_raddr1 (w_rt),
        .i_raddr2 (dbg_addr),
        .o_rdata0 (w_rdata_s),
        .o_rdata1 (w_rdata_t),
        .o_rdata2 (dbg_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_instr     <= '0;
            r_result    <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_ctrl  <= ALUC_ADD;
            r_zero      <= 1'b0;
            r_bad       <= 1'b0;
            r_done      <= 1'b0;
            r_illegal   <= 1'b0;
            r_zero_flag <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (instr_valid) begin
                        r_instr <= instr;
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    r_bad <= !is_legal(w_op);
                    if (is_legal(w_op)) begin
                        r_alu_a    <= w_rdata_s;
                        r_alu_b    <= w_op == OP_ADDI ? sext6(r_instr[5:0]) : w_rdata_t;
                        r_alu_ctrl <= op_to_aluc(w_op);
                        r_state    <= S_EXEC;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_EXEC: begin
                    r_result <= alu_result;
                    r_zero   <= alu_zero;
                    r_state  <= S_WB;
                end
                S_WB: begin
                    r_done    <= 1'b1;
                    r_illegal <= r_bad;
                    if (!r_bad) r_zero_flag <= r_zero;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Ready is gated by rst_n so it drops immediately while reset is held.
    assign instr_ready = rst_n && r_state == S_IDLE;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_control = r_alu_ctrl;
    assign done        = r_done;
    assign illegal     = r_illegal;
    assign zero_flag   = r_zero_flag;
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Multi-cycle instruction issue/writeback controller that drives the 16-bit ALU.
- Accepts one 16-bit instruction at a time over a valid/ready handshake and decodes it to ALU operands plus a 3-bit alu_control code.
- Samples the ALU's combinational result and zero flag, then writes the result back to an internal 8x16 register file.
- Sits between the fetch stage and the ALU.

Parameters:
DATA_W, 16, datapath and register width
NUM_REGS, 8, register file depth (address width = 3)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
instr_valid  input  1  instruction present on instr
instr_ready  output  1  controller can accept an instruction
instr  input  16  instruction word
alu_a  output  16  ALU operand A
alu_b  output  16  ALU operand B
alu_control  output  3  ALU op: 000 ADD, 001 SUB, 010 SLL, 011 AND
alu_result  input  16  ALU combinational result
alu_zero  input  1  ALU zero flag (result == 0)
done  output  1  one-cycle pulse: instruction retired
illegal  output  1  one-cycle pulse with done: opcode was illegal
zero_flag  output  1  sticky copy of alu_zero from the last legal retired instruction
dbg_addr  input  3  debug register read address
dbg_data  output  16  combinational register file read at dbg_addr

Behaviour:
- Instruction format:
  - [15:12] opcode, [11:9] rd, [8:6] rs, [5:3] rt.
  - I-type uses [5:0] imm6, sign-extended to 16 bits.
- Opcode mapping:
  - 0000 ADD, 0001 SUB, 0010 SLL, 0011 AND: alu_a = R[rs], alu_b = R[rt], alu_control = 000/001/010/011.
  - 0100 ADDI: alu_a = R[rs], alu_b = sext(imm6), alu_control = 000.
  - All other opcodes are illegal.
- Reset (async, rst_n low):
  - State goes to IDLE; all registers cleared to 0.
  - alu_a = alu_b = 0, alu_control = 000.
  - done = illegal = zero_flag = 0; instr_ready = 0 while rst_n is low.
  - Any in-flight instruction is dropped with no writeback.
- FSM states: IDLE, READ, EXEC, WB.
  - IDLE: instr_ready = 1. A handshake (instr_valid & instr_ready) captures instr into instr_q, then goes to READ. No handshake keeps IDLE.
  - READ: decode instr_q, read R[rs]/R[rt], and register the ALU operand/control outputs. Legal opcode goes to EXEC; illegal opcode goes to WB with the illegal flag set, leaving the ALU outputs unchanged.
  - EXEC: the ALU outputs are stable. At the end of the cycle, capture alu_result and alu_zero into result_q and zero_q, then go to WB.
  - WB:
    - Legal: write result_q to R[rd] unless rd == 0, and update zero_flag from zero_q.
    - Always pulse done; pulse illegal only for an illegal opcode.
    - Return to IDLE.
  - instr_ready is 0 in READ, EXEC and WB.
- Latency:
  - Handshake on edge N gives done high during the cycle after edge N+3; the next handshake is possible at edge N+4.
  - Throughput: 1 instruction per 4 cycles.
  - Illegal instructions retire in 3 cycles (READ -> WB).
- Register file:
  - R0 reads as 0; writes to R0 are discarded. For a write to R0, zero_flag still updates from the ALU zero.
  - Single write port (WB only) and two read ports plus the debug port, all combinational.
- Arithmetic:
  - ADD/SUB wrap modulo 2^16.
  - SLL uses the full 16-bit R[rt] as the shift amount; amounts >= 16 give 0 (ALU behaviour; the controller forwards it unchanged).
- Outputs held: alu_a, alu_b and alu_control keep their last values outside READ updates.
- Hazard: rd == rs of the next instruction needs no forwarding, since WB completes before the next READ.
- instr_valid while not ready: ignored. instr may change freely until the handshake.

Decomposition:
- Shared package alu_pkg:
  - Opcode constants OP_ADD..OP_ADDI.
  - ALU control constants ALUC_ADD = 3'b000, ALUC_SUB = 3'b001, ALUC_SLL = 3'b010, ALUC_AND = 3'b011.
  - FSM state encoding; DATA_W.
- Sub-module alu_regfile: NUM_REGS x DATA_W, R0 hardwired to 0, async clear on rst_n, 1 write port and 3 combinational read ports.

Test Plan:
- ADDI r1, r0, 5; ADDI r2, r0, 3; ADD r3, r1, r2 -> alu_control = 000, dbg R3 = 8, done exactly 4 cycles after each handshake, zero_flag = 0.
- SUB r4, r2, r1 -> R4 = 0xFFFE. Then SUB r5, r1, r1 -> R5 = 0 and zero_flag = 1.
- SLL r6, r1, r2 -> alu_control = 010, R6 = 40. AND r7, r6, r1 (40 & 5) -> R7 = 0 and zero_flag = 1.
- Opcode 0xF, rd = 1 -> done and illegal pulse together 3 cycles after the handshake; R1 stays 5; zero_flag unchanged.
- ADDI r0, r0, -1 (imm6 = 0x3F) -> alu_b = 0xFFFF, R0 reads 0, zero_flag = 0. Hold instr_valid high back-to-back -> instr_ready only in IDLE, one handshake per 4 cycles.
- Assert rst_n low during EXEC of ADD r3 -> immediate IDLE, all registers 0, no done pulse, alu outputs 0. After release, the first instruction executes normally.
